// File: rtl/tx_send_scheduler.sv
// tx_send_scheduler: round-robin launch of pending message slots into the TX FSM,
// with a watchdog that aborts a send whose completion never arrives.
module tx_send_scheduler #(
    parameter  int NUM_MSGS       = 4,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int ID_W           = $clog2(NUM_MSGS),
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                enable,
    input  logic [NUM_MSGS-1:0] trigger_send,
    output logic                send_valid,
    output logic [ID_W-1:0]     send_msg_id,
    input  logic                send_ready,
    input  logic                send_done,
    output logic [NUM_MSGS-1:0] pending,
    output logic                busy,
    output logic                done_pulse,
    output logic                timeout_err,
    output logic                retrigger_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_t;

    state_t              state, state_n;
    logic [ID_W-1:0]     rr_ptr, rr_n, id_n, winner, idx;
    logic [TW-1:0]       timer, timer_n;
    logic [NUM_MSGS-1:0] clr;
    logic                found, fire, valid_n, done_n, tout_n;

    assign fire = (state == REQ) && send_ready;
    assign clr  = fire ? (NUM_MSGS'(1) << send_msg_id) : '0;

    // First pending slot at or after rr_ptr; power-of-2 slot count makes the wrap free.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_MSGS; i++) begin
            idx = rr_ptr + ID_W'(i);
            if (!found && pending[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        valid_n = send_valid;
        id_n    = send_msg_id;
        rr_n    = rr_ptr;
        timer_n = timer;
        done_n  = 1'b0;
        tout_n  = 1'b0;
        case (state)
            IDLE: if (enable && found) begin
                state_n = REQ;
                valid_n = 1'b1;
                id_n    = winner;
            end
            REQ: if (send_ready) begin
                state_n = WAIT_DONE;
                valid_n = 1'b0;
                rr_n    = send_msg_id + ID_W'(1);
                timer_n = '0;
            end
            WAIT_DONE: begin
                timer_n = timer + TW'(1);
                if (send_done) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    tout_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            pending       <= '0;
            rr_ptr        <= '0;
            send_valid    <= 1'b0;
            send_msg_id   <= '0;
            busy          <= 1'b0;
            timer         <= '0;
            done_pulse    <= 1'b0;
            timeout_err   <= 1'b0;
            retrigger_err <= 1'b0;
        end else begin
            state         <= state_n;
            pending       <= (pending & ~clr) | trigger_send;
            rr_ptr        <= rr_n;
            send_valid    <= valid_n;
            send_msg_id   <= id_n;
            busy          <= (state_n != IDLE);
            timer         <= timer_n;
            done_pulse    <= done_n;
            timeout_err   <= tout_n;
            retrigger_err <= |(trigger_send & pending & ~clr);
        end
    end
endmodule

// File: tb/tb_tx_send_scheduler.sv
// tb_tx_send_scheduler: scenario tasks with a grant-order scoreboard for tx_send_scheduler
// (4 slots, 8-cycle watchdog).
module tb_tx_send_scheduler;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       enable = 1'b1;
    logic [3:0] trigger_send = '0;
    logic       send_valid;
    logic [1:0] send_msg_id;
    logic       send_ready = 1'b0;
    logic       send_done = 1'b0;
    logic [3:0] pending;
    logic       busy, done_pulse, timeout_err, retrigger_err;

    int         checks = 0;
    int         passed = 0;
    logic [1:0] sb[$];

    tx_send_scheduler #(.NUM_MSGS(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .n_rst(n_rst), .enable(enable), .trigger_send(trigger_send),
        .send_valid(send_valid), .send_msg_id(send_msg_id), .send_ready(send_ready),
        .send_done(send_done), .pending(pending), .busy(busy), .done_pulse(done_pulse),
        .timeout_err(timeout_err), .retrigger_err(retrigger_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        enable = 1'b1;
        trigger_send = '0;
        send_ready = 1'b0;
        send_done = 1'b0;
        repeat (2) tick();
        n_rst = 1'b1;
        tick();
        sb.delete();
    endtask

    task automatic trig(input logic [3:0] v);
        trigger_send = v;
        tick();
        trigger_send = '0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (send_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Waits for a launch request and accepts it; returns with the machine in WAIT_DONE.
    task automatic launch(output logic [1:0] id, output bit ok);
        wait_valid(ok);
        id = send_msg_id;
        if (ok) begin
            send_ready = 1'b1;
            tick();
            send_ready = 1'b0;
        end
    endtask

    task automatic finish_send();
        send_done = 1'b1;
        tick();
        send_done = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({send_valid, send_msg_id, pending, busy, done_pulse, timeout_err, retrigger_err} !== 11'b0)
            $display("FAIL reset_state: got %b required 0", {send_valid, send_msg_id, pending, busy, done_pulse, timeout_err, retrigger_err});
        else passed++;
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [1:0] exp;
        do_reset();
        sb.push_back(2'd2);
        trig(4'b0100);
        checks++;
        if ({pending, send_valid} !== {4'b0100, 1'b0})
            $display("FAIL single_pending: got %b/%b required 0100/0", pending, send_valid);
        else passed++;
        tick();
        exp = sb.pop_front();
        checks++;
        if ({send_valid, send_msg_id} !== {1'b1, exp})
            $display("FAIL single_launch: got valid=%b id=%0d required valid=1 id=%0d", send_valid, send_msg_id, exp);
        else passed++;
        send_ready = 1'b1;
        tick();
        send_ready = 1'b0;
        checks++;
        if ({pending, send_valid, busy} !== {4'b0000, 1'b0, 1'b1})
            $display("FAIL single_accept: got pending=%b valid=%b busy=%b required 0000/0/1", pending, send_valid, busy);
        else passed++;
        repeat (4) tick();
        finish_send();
        checks++;
        if ({done_pulse, busy, timeout_err} !== 3'b100)
            $display("FAIL single_done: got done=%b busy=%b tout=%b required 1/0/0", done_pulse, busy, timeout_err);
        else passed++;
        tick();
        checks++;
        if (done_pulse !== 1'b0)
            $display("FAIL single_done_width: got %b required 0", done_pulse);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [3:0] v;
        logic [1:0] id, exp;
        bit ok;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            v = (r == 0) ? 4'b1011 : 4'b0011;
            for (int s = 0; s < 4; s++) if (v[s]) sb.push_back(s[1:0]);
            trig(v);
            while (sb.size() > 0) begin
                exp = sb.pop_front();
                launch(id, ok);
                checks++;
                if (!ok || id !== exp)
                    $display("FAIL rr_grant: got ok=%0d id=%0d required id=%0d", ok, id, exp);
                else passed++;
                finish_send();
                checks++;
                if (done_pulse !== 1'b1)
                    $display("FAIL rr_done: got %b required 1", done_pulse);
                else passed++;
            end
        end
    endtask

    task automatic test_retrigger();
        logic [1:0] id, exp;
        bit ok;
        do_reset();
        sb.push_back(2'd0);
        trig(4'b0001);
        launch(id, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || id !== exp) $display("FAIL retrig_first_grant: got id=%0d required %0d", id, exp);
        else passed++;
        sb.push_back(2'd1);
        trig(4'b0010);
        checks++;
        if (retrigger_err !== 1'b0) $display("FAIL retrig_fresh: got %b required 0", retrigger_err);
        else passed++;
        trig(4'b0010);
        checks++;
        if (retrigger_err !== 1'b1) $display("FAIL retrig_dup: got %b required 1", retrigger_err);
        else passed++;
        sb.push_back(2'd0);
        trig(4'b0001);
        checks++;
        if ({retrigger_err, pending} !== {1'b0, 4'b0011})
            $display("FAIL retrig_active_requeue: got err=%b pending=%b required 0/0011", retrigger_err, pending);
        else passed++;
        finish_send();
        for (int n = 0; n < 2; n++) begin
            exp = sb.pop_front();
            launch(id, ok);
            checks++;
            if (!ok || id !== exp) $display("FAIL retrig_order: got ok=%0d id=%0d required %0d", ok, id, exp);
            else passed++;
            finish_send();
        end
        checks++;
        if ({pending, busy} !== 5'b0) $display("FAIL retrig_drained: got pending=%b busy=%b required 0000/0", pending, busy);
        else passed++;
    endtask

    task automatic test_timeout();
        logic [1:0] id, exp;
        bit ok;
        int k;
        do_reset();
        sb.push_back(2'd2);
        trig(4'b0100);
        launch(id, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || id !== exp) $display("FAIL tout_grant: got id=%0d required %0d", id, exp);
        else passed++;
        trigger_send = 4'b1000;
        sb.push_back(2'd3);
        k = 0;
        while (k < 12 && !timeout_err) begin
            tick();
            trigger_send = '0;
            k++;
        end
        checks++;
        if (k !== 8 || timeout_err !== 1'b1)
            $display("FAIL tout_latency: got %0d cycles required 8", k);
        else passed++;
        checks++;
        if ({busy, done_pulse, pending} !== {1'b0, 1'b0, 4'b1000})
            $display("FAIL tout_state: got busy=%b done=%b pending=%b required 0/0/1000", busy, done_pulse, pending);
        else passed++;
        tick();
        exp = sb.pop_front();
        checks++;
        if ({send_valid, send_msg_id, timeout_err} !== {1'b1, exp, 1'b0})
            $display("FAIL tout_next_launch: got valid=%b id=%0d tout=%b required 1/%0d/0", send_valid, send_msg_id, timeout_err, exp);
        else passed++;
        send_ready = 1'b1;
        tick();
        send_ready = 1'b0;
        finish_send();
    endtask

    task automatic test_handshake_hold();
        logic [1:0] id, exp;
        bit ok;
        do_reset();
        sb.push_back(2'd1);
        trig(4'b0010);
        wait_valid(ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || send_msg_id !== exp) $display("FAIL hold_grant: got id=%0d required %0d", send_msg_id, exp);
        else passed++;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({send_valid, send_msg_id} !== {1'b1, exp})
                $display("FAIL hold_cycle%0d: got valid=%b id=%0d required 1/%0d", i, send_valid, send_msg_id, exp);
            else passed++;
        end
        send_ready = 1'b1;
        tick();
        send_ready = 1'b0;
        finish_send();
        trig(4'b0001);
        repeat (4) tick();
        checks++;
        if ({send_valid, busy, pending} !== {1'b0, 1'b0, 4'b0001})
            $display("FAIL hold_disabled: got valid=%b busy=%b pending=%b required 0/0/0001", send_valid, busy, pending);
        else passed++;
        enable = 1'b1;
        sb.push_back(2'd0);
        launch(id, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || id !== exp) $display("FAIL hold_reenable: got ok=%0d id=%0d required %0d", ok, id, exp);
        else passed++;
        finish_send();
    endtask

    task automatic test_async_reset();
        logic [1:0] id;
        bit ok;
        do_reset();
        trig(4'b0001);
        launch(id, ok);
        trig(4'b1110);
        checks++;
        if ({pending, busy} !== {4'b1110, 1'b1})
            $display("FAIL areset_setup: got pending=%b busy=%b required 1110/1", pending, busy);
        else passed++;
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({send_valid, send_msg_id, pending, busy, done_pulse, timeout_err, retrigger_err} !== 11'b0)
            $display("FAIL areset_immediate: got %b required 0", {send_valid, send_msg_id, pending, busy, done_pulse, timeout_err, retrigger_err});
        else passed++;
        tick();
        n_rst = 1'b1;
        repeat (5) tick();
        checks++;
        if ({send_valid, busy, pending, done_pulse} !== 7'b0)
            $display("FAIL areset_quiet: got valid=%b busy=%b pending=%b done=%b required 0", send_valid, busy, pending, done_pulse);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_retrigger();
        test_timeout();
        test_handshake_hold();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
